// File: rtl/instr_decode_issue.sv
// instr_decode_issue
//   Buffers MIPS R-format instruction words in a 4-entry FIFO, then decodes
//   and issues them one per cycle unless the downstream stage holds.
//   Decoded fields are registered; they keep their last values between issues.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     upstream instruction valid
//   in_ready     block can accept an instruction (FIFO not full)
//   instr        32-bit instruction word
//   hold         downstream stall, blocks issue
//   rd_addr1     rs field of the issued instruction
//   rd_addr2     rt field of the issued instruction
//   wr_addr      rd field of the issued instruction
//   shamt        shift amount of the issued instruction
//   funct        4-bit ALU operation code
//   RegWrite     register write enable for the issued instruction
//   issue_valid  outputs carry a newly issued instruction this cycle
//   illegal_cnt  saturating count of illegal instructions issued
//
// Configuration
//   ILLEGAL_CNT_EN  when defined, illegal_cnt counts illegal issues
//                   (saturating at 255); otherwise it is tied to 0.

module instr_decode_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        hold,
   output logic [4:0]  rd_addr1,
   output logic [4:0]  rd_addr2,
   output logic [4:0]  wr_addr,
   output logic [4:0]  shamt,
   output logic [3:0]  funct,
   output logic        RegWrite,
   output logic        issue_valid,
   output logic [7:0]  illegal_cnt
);

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PTR_W   = 2;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned INSTR_W = 32;

   logic [INSTR_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic [INSTR_W-1:0] head;
   logic [3:0]         dec_funct;
   logic               dec_legal;

   assign in_ready = (count != CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count != CNT_W'(0)) && !hold;
   assign head     = fifo_mem[rd_ptr];

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= instr;
      end
   end

   // Pointers wrap naturally at 2 bits; count is unchanged on push+pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Function-field decode; non-zero opcode or unknown funct is illegal.
   always_comb begin
      dec_funct = 4'b0000;
      dec_legal = 1'b1;
      case (head[5:0])
         6'b100100: dec_funct = 4'b0000;
         6'b100101: dec_funct = 4'b0001;
         6'b100000: dec_funct = 4'b0010;
         6'b100110: dec_funct = 4'b0011;
         6'b100010: dec_funct = 4'b0110;
         6'b101010: dec_funct = 4'b0111;
         6'b100111: dec_funct = 4'b1100;
         6'b000000: dec_funct = 4'b1000;
         6'b000010: dec_funct = 4'b1001;
         6'b000011: dec_funct = 4'b1010;
         default:   dec_legal = 1'b0;
      endcase
      if (head[31:26] != 6'd0) begin
         dec_legal = 1'b0;
      end
      if (!dec_legal) begin
         dec_funct = 4'b0000;
      end
   end

   // Issue register: fields hold between issues, strobes drop to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr1    <= '0;
         rd_addr2    <= '0;
         wr_addr     <= '0;
         shamt       <= '0;
         funct       <= '0;
         RegWrite    <= 1'b0;
         issue_valid <= 1'b0;
      end else if (pop) begin
         rd_addr1    <= head[25:21];
         rd_addr2    <= head[20:16];
         wr_addr     <= head[15:11];
         shamt       <= head[10:6];
         funct       <= dec_funct;
         RegWrite    <= dec_legal && (head[15:11] != 5'd0);
         issue_valid <= 1'b1;
      end else begin
         RegWrite    <= 1'b0;
         issue_valid <= 1'b0;
      end
   end

`ifdef ILLEGAL_CNT_EN
   // Saturating illegal-issue counter, updated on the issuing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_cnt <= '0;
      end else if (pop && !dec_legal && (illegal_cnt != 8'hFF)) begin
         illegal_cnt <= illegal_cnt + 8'd1;
      end
   end
`else
   assign illegal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_instr_decode_issue.sv
// tb_instr_decode_issue
//   Scoreboard bench for instr_decode_issue: expected decodes are queued as
//   instructions are accepted and compared when the block issues them.

module tb_instr_decode_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        hold;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [4:0]  wr_addr;
   logic [4:0]  shamt;
   logic [3:0]  funct;
   logic        RegWrite;
   logic        issue_valid;
   logic [7:0]  illegal_cnt;

   instr_decode_issue dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .hold        (hold),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .wr_addr     (wr_addr),
      .shamt       (shamt),
      .funct       (funct),
      .RegWrite    (RegWrite),
      .issue_valid (issue_valid),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] r1;
      logic [4:0] r2;
      logic [4:0] wr;
      logic [4:0] sh;
      logic [3:0] fn;
      logic       rw;
      logic       ill;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   int          n_issued = 0;
   int          exp_ill  = 0;
   logic [23:0] last_f   = '0;
   logic [5:0]  legal_f [10] = '{6'b100100, 6'b100101, 6'b100000, 6'b100110, 6'b100010,
                                 6'b101010, 6'b100111, 6'b000000, 6'b000010, 6'b000011};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t       e;
      logic [3:0] f;
      logic       ok;
      ok = 1'b1;
      f  = 4'b0000;
      case (w[5:0])
         6'b100100: f = 4'b0000;
         6'b100101: f = 4'b0001;
         6'b100000: f = 4'b0010;
         6'b100110: f = 4'b0011;
         6'b100010: f = 4'b0110;
         6'b101010: f = 4'b0111;
         6'b100111: f = 4'b1100;
         6'b000000: f = 4'b1000;
         6'b000010: f = 4'b1001;
         6'b000011: f = 4'b1010;
         default:   ok = 1'b0;
      endcase
      if (w[31:26] != 6'd0) ok = 1'b0;
      e.r1  = w[25:21];
      e.r2  = w[20:16];
      e.wr  = w[15:11];
      e.sh  = w[10:6];
      e.fn  = ok ? f : 4'b0000;
      e.rw  = ok && (w[15:11] != 5'd0);
      e.ill = !ok;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 5) != 0) w[31:26] = 6'd0;
      if ($urandom_range(0, 4) != 0) w[5:0] = legal_f[$urandom_range(0, 9)];
      return w;
   endfunction

   // Output monitor: pops the scoreboard on each issue; checks idle behaviour otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         if (issue_valid) begin
            n_issued++;
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rd_addr1", 32'(rd_addr1), 32'(mon_e.r1));
               chk("rd_addr2", 32'(rd_addr2), 32'(mon_e.r2));
               chk("wr_addr",  32'(wr_addr),  32'(mon_e.wr));
               chk("shamt",    32'(shamt),    32'(mon_e.sh));
               chk("funct",    32'(funct),    32'(mon_e.fn));
               chk("regwrite", 32'(RegWrite), 32'(mon_e.rw));
`ifdef ILLEGAL_CNT_EN
               if (mon_e.ill && exp_ill < 255) exp_ill++;
`endif
               chk("illegal_cnt", 32'(illegal_cnt), 32'(exp_ill));
            end
            last_f = {rd_addr1, rd_addr2, wr_addr, shamt, funct};
         end else begin
            chk("idle_regwrite", 32'(RegWrite), 32'd0);
            chk("idle_hold_fields", 32'({rd_addr1, rd_addr2, wr_addr, shamt, funct}), 32'(last_f));
         end
      end
   end

   // Offer one instruction (called at a negedge); returns one negedge after acceptance.
   task automatic send(input logic [31:0] w);
      int n;
      n        = 0;
      in_valid = 1'b1;
      instr    = w;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 32'd1, 32'd0);
      end else begin
         exp_q.push_back(model(w));
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] w5;
      int          n0;

      rst      = 1'b1;
      in_valid = 1'b0;
      hold     = 1'b0;
      instr    = '0;
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      chk("rst_regwrite",    32'(RegWrite),    32'd0);
      chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
      chk("rst_fields", 32'({rd_addr1, rd_addr2, wr_addr, shamt, funct}), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // ADD, one-edge latency with no bypass
      send(32'h012A4020);
      chk("no_bypass", 32'(issue_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid",  32'(issue_valid), 32'd1);
      chk("add_rd1",    32'(rd_addr1),    32'd9);
      chk("add_rd2",    32'(rd_addr2),    32'd10);
      chk("add_wr",     32'(wr_addr),     32'd8);
      chk("add_funct",  32'(funct),       32'b0010);
      chk("add_rw",     32'(RegWrite),    32'd1);

      // SLL with shift amount
      send(32'h00031100);
      @(negedge clk);
      chk("sll_shamt", 32'(shamt), 32'd4);
      chk("sll_funct", 32'(funct), 32'b1000);
      chk("sll_rw",    32'(RegWrite), 32'd1);

      // Write to r0 suppresses RegWrite
      send(32'h00220020);
      @(negedge clk);
      chk("r0_valid", 32'(issue_valid), 32'd1);
      chk("r0_rw",    32'(RegWrite),    32'd0);
      chk("r0_funct", 32'(funct),       32'b0010);

      // Illegal opcode (lw)
      send(32'h8D280004);
      @(negedge clk);
      chk("ill_valid", 32'(issue_valid), 32'd1);
      chk("ill_funct", 32'(funct),       32'd0);
      chk("ill_rw",    32'(RegWrite),    32'd0);
`ifdef ILLEGAL_CNT_EN
      chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
`else
      chk("ill_cnt1", 32'(illegal_cnt), 32'd0);
`endif

      // Fill under hold, 5th blocked, then consecutive drain
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = {6'd0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), 6'b100101};
         send(w);
      end
      w5       = {6'd0, 5'd20, 5'd21, 5'd22, 5'd0, 6'b101010};
      in_valid = 1'b1;
      instr    = w5;
      chk("full_not_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("full_still_blocked", 32'(in_ready), 32'd0);
      chk("full_no_issue", 32'(issue_valid), 32'd0);
      hold = 1'b0;
      #1 n0 = n_issued;
      @(negedge clk);
      chk("ready_after_pop", 32'(in_ready), 32'd1);
      send(w5);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("consec_issues", 32'(n_issued - n0), 32'd4);
      drain();

      // Illegal counter saturation
      for (int i = 0; i < 300; i++) send(32'h8D280004);
      drain();
`ifdef ILLEGAL_CNT_EN
      chk("ill_sat", 32'(illegal_cnt), 32'd255);
`else
      chk("ill_sat", 32'(illegal_cnt), 32'd0);
`endif

      // Random traffic with random stalls
      for (int c = 0; c < 400; c++) begin
         hold = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) begin
            w        = rand_instr();
            in_valid = 1'b1;
            instr    = w;
            if (in_ready) exp_q.push_back(model(w));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      hold     = 1'b0;
      drain();

      // Reset mid-operation discards queued entries
      send(32'h012A4020);
      drain();
      hold = 1'b1;
      send(32'h00031100);
      send(32'h00220020);
      send(32'h012A4020);
      #2 rst = 1'b1;
      #1;
      chk("mrst_issue_valid", 32'(issue_valid), 32'd0);
      chk("mrst_in_ready",    32'(in_ready),    32'd1);
      chk("mrst_rd1",         32'(rd_addr1),    32'd0);
      chk("mrst_wr",          32'(wr_addr),     32'd0);
      chk("mrst_funct",       32'(funct),       32'd0);
      chk("mrst_regwrite",    32'(RegWrite),    32'd0);
      chk("mrst_illegal_cnt", 32'(illegal_cnt), 32'd0);
      exp_q.delete();
      last_f  = '0;
      exp_ill = 0;
      @(negedge clk);
      #2;
      rst  = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1 chk("post_rst_idle", 32'(issue_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_decode_issue.md
INSTR_DECODE_ISSUE -- requirements
Module: instr_decode_issue

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-004 SHALL have port in_ready  output  1  block can accept; equals (count != 4).
REQ-005 SHALL have port instr  input  32  MIPS R-format instruction word.
REQ-006 SHALL have port hold  input  1  downstream stall; blocks issue.
REQ-007 SHALL have ports rd_addr1, rd_addr2, wr_addr  output  5 each  rs, rt, rd fields of issued instruction.
REQ-008 SHALL have ports shamt  output  5; funct  output  4  ALU operation code.
REQ-009 SHALL have ports RegWrite  output  1  write enable for issued instruction; issue_valid  output  1  outputs carry a new instruction this cycle.
REQ-010 SHALL have port illegal_cnt  output  8  illegal-instruction count (see Configuration).

Function
REQ-011 SHALL buffer instructions in a 4-entry FIFO; push when in_valid && in_ready at a rising edge.
REQ-012 SHALL pop the head at a rising edge when count != 0 and hold == 0, registering decoded fields onto the outputs with issue_valid=1 after that edge.
REQ-013 SHALL have latency 1 edge: an instruction pushed into an empty FIFO at edge k appears on the outputs after edge k+1 if hold=0; no bypass.
REQ-014 SHALL allow simultaneous push and pop for count 1..3; count stays unchanged.
REQ-015 SHALL, in cycles with no pop, drive issue_valid=0 and RegWrite=0 and hold the address, shamt and funct outputs at their last values.
REQ-016 SHALL map instr[5:0] to funct: 100100->0000 AND, 100101->0001 OR, 100000->0010 ADD, 100110->0011 XOR, 100010->0110 SUB, 101010->0111 SLT, 100111->1100 NOR, 000000->1000 SLL, 000010->1001 SRL, 000011->1010 SRA.
REQ-017 SHALL drive rd_addr1=instr[25:21], rd_addr2=instr[20:16], wr_addr=instr[15:11], shamt=instr[10:6].
REQ-018 SHALL treat opcode instr[31:26] != 0, or a funct not in REQ-016, as illegal: issue with issue_valid=1, RegWrite=0, funct=0000.
REQ-019 SHALL drive RegWrite=0 for a legal instruction whose wr_addr is 0; otherwise RegWrite=1 on issue.
REQ-020 SHALL issue in strict FIFO order; wrap-around of the 2-bit read and write pointers SHALL be transparent.

Reset
REQ-021 SHALL, while rst=1, immediately force all outputs to 0 except in_ready=1, and clear count, pointers and illegal_cnt.
REQ-022 SHALL discard all queued instructions on reset mid-operation; no queued instruction issues after rst is released.

Configuration
REQ-023 SHALL, with macro ILLEGAL_CNT_EN defined, increment illegal_cnt by 1 on each illegal issue, saturating at 255.
REQ-024 SHALL, without ILLEGAL_CNT_EN, tie illegal_cnt to 0 and implement no counter logic.

Verification
REQ-025 Push 0x012A4020 into the empty FIFO -> one edge later: issue_valid=1, rd_addr1=9, rd_addr2=10, wr_addr=8, shamt=0, funct=0010, RegWrite=1.
REQ-026 Push 0x00031100 -> rd_addr1=0, rd_addr2=3, wr_addr=2, shamt=4, funct=1000, RegWrite=1.
REQ-027 With hold=1, offer 5 back-to-back instructions -> 4 accepted, in_ready=0 while the 5th is offered; release hold -> 4 issues in order on consecutive cycles, then 5th accepted.
REQ-028 Push 0x8D280004 with ILLEGAL_CNT_EN -> issue_valid=1, RegWrite=0, funct=0000, illegal_cnt=1; repeat 300 times -> illegal_cnt=255.
REQ-029 Push 0x00220020 -> wr_addr=0, funct=0010, RegWrite=0, issue_valid=1.
REQ-030 Queue 3 entries with hold=1, assert rst between edges -> outputs 0 and in_ready=1 before the next edge; deassert rst, hold=0 -> issue_valid stays 0.
